// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: constants shared by the prefetch unit, the length
// decoder and the tools that reuse the decoder (disassembler, trace monitor).
//   DEFAULT_*        default widths and the post-reset fetch address
//   am3_t            bbb field (opcode[4:2]) addressing-mode codes
//   LEN_1..LEN_3     instruction length codes as carried on instr_len
package fetch_queue_pkg;

  localparam int DEFAULT_ADDR_WIDTH       = 16;
  localparam int DEFAULT_REG_WIDTH        = 8;
  localparam int DEFAULT_INSTRUCTION_BASE = 32'h0000_0600;

  // Names follow the cc=01 group; the same bbb values select other modes
  // in the cc=00/10 groups, which the length decoder handles explicitly.
  typedef enum logic [2:0] {
    AM3_ZPX_IND  = 3'b000,
    AM3_ZP       = 3'b001,
    AM3_IMM      = 3'b010,
    AM3_ABS      = 3'b011,
    AM3_ZP_IND_Y = 3'b100,
    AM3_ZPX      = 3'b101,
    AM3_ABSY     = 3'b110,
    AM3_ABSX     = 3'b111
  } am3_t;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

endpackage

// File: rtl/fetch_queue_len_decode.sv
// fetch_len_decode: combinational opcode -> instruction length (1..3 bytes).
//   opcode     in   REG_WIDTH  opcode byte (only bits [7:0] are meaningful)
//   instr_len  out  2          LEN_1 / LEN_2 / LEN_3
module fetch_len_decode
  import fetch_queue_pkg::*;
#(
  parameter int REG_WIDTH = DEFAULT_REG_WIDTH
) (
  input  logic [REG_WIDTH-1:0] opcode,
  output logic [1:0]           instr_len
);

  logic [1:0] cc;
  am3_t       bbb;

  always_comb begin
    cc        = opcode[1:0];
    bbb       = am3_t'(opcode[4:2]);
    instr_len = LEN_1;
    if (opcode[7:0] == 8'h20) begin
      // JSR abs sits in a group that is otherwise single-byte.
      instr_len = LEN_3;
    end else if (opcode[7:0] inside {8'hA0, 8'hA2, 8'hC0, 8'hE0}) begin
      // LDY/LDX/CPY/CPX immediate.
      instr_len = LEN_2;
    end else if (cc == 2'b01) begin
      // ALU group: every mode carries an operand; absolute forms take two.
      if (bbb inside {AM3_ABS, AM3_ABSY, AM3_ABSX}) instr_len = LEN_3;
      else                                         instr_len = LEN_2;
    end else if (cc == 2'b11) begin
      instr_len = LEN_1;
    end else if (cc == 2'b10 && bbb == AM3_ZP_IND_Y) begin
      instr_len = LEN_1;
    end else begin
      case (bbb)
        AM3_ABS, AM3_ABSX:             instr_len = LEN_3;
        AM3_ZP, AM3_ZP_IND_Y, AM3_ZPX: instr_len = LEN_2;
        default:                       instr_len = LEN_1;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetch and 1..3 byte assembly.
//   phi1, reset_n          clock; synchronous active-low reset
//   mem_addr/req/grant     read request port, accepted when req && grant
//   data_in                read data, valid one cycle after an accept
//   redirect_valid/addr    flush everything and restart fetch at addr
//   instr_valid/ready      instruction handshake to decode/execute
//   opcode, operand        assembled instruction, operand = {hi, lo}
//   instr_len, instr_pc    length 1..3 and address of the opcode byte
// Handshake: an instruction transfers on a posedge where instr_valid and
// instr_ready are both high; while instr_valid && !instr_ready every
// instruction output holds its value.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                    ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
  parameter int                    REG_WIDTH        = DEFAULT_REG_WIDTH,
  parameter int                    QUEUE_DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] INSTRUCTION_BASE = ADDR_WIDTH'(DEFAULT_INSTRUCTION_BASE)
) (
  input  logic                   phi1,
  input  logic                   reset_n,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_req,
  input  logic                   mem_grant,
  input  logic [REG_WIDTH-1:0]   data_in,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [REG_WIDTH-1:0]   opcode,
  output logic [2*REG_WIDTH-1:0] operand,
  output logic [1:0]             instr_len,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  logic [REG_WIDTH-1:0]  q [QUEUE_DEPTH];
  logic [PW-1:0]         head_ptr, tail_ptr;
  logic [CW-1:0]         count;
  logic                  pending;
  logic [ADDR_WIDTH-1:0] fetch_addr, head_addr;

  logic [REG_WIDTH-1:0]  win [3];
  logic [REG_WIDTH-1:0]  op_lo, op_hi;
  logic [1:0]            head_len;
  logic [OW-1:0]         occupancy;
  logic                  accept, assemble;
  logic [CW-1:0]         pop_count;

  // Three-byte view of the queue head. Bytes past the stored count come
  // from data_in, so the byte returning this cycle can complete an
  // instruction without first spending a cycle in the queue.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win[i] = (CW'(i) < count) ? q[head_ptr + PW'(i)] : data_in;
    end
    op_lo = (head_len != LEN_1) ? win[1] : '0;
    op_hi = (head_len == LEN_3) ? win[2] : '0;
  end

  fetch_len_decode #(.REG_WIDTH(REG_WIDTH)) u_len_decode (
    .opcode    (win[0]),
    .instr_len (head_len)
  );

  // count + pending serves both as the reservation check for a new request
  // and as the bytes usable this cycle (a pending read always returns now).
  assign occupancy = {1'b0, count} + OW'(pending);
  assign mem_req   = !redirect_valid && (occupancy < OW'(QUEUE_DEPTH));
  assign mem_addr  = fetch_addr;
  assign accept    = mem_req && mem_grant;
  assign assemble  = !redirect_valid && (occupancy >= OW'(head_len)) &&
                     (!instr_valid || instr_ready);
  assign pop_count = assemble ? CW'(head_len) : '0;

  always_ff @(posedge phi1) begin
    if (!reset_n) begin
      fetch_addr  <= INSTRUCTION_BASE;
      head_addr   <= INSTRUCTION_BASE;
      head_ptr    <= '0;
      tail_ptr    <= '0;
      count       <= '0;
      pending     <= 1'b0;
      instr_valid <= 1'b0;
      opcode      <= '0;
      operand     <= '0;
      instr_len   <= '0;
      instr_pc    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= '0;
    end else if (redirect_valid) begin
      // Clearing pending discards the read still in flight.
      fetch_addr  <= redirect_addr;
      head_addr   <= redirect_addr;
      head_ptr    <= '0;
      tail_ptr    <= '0;
      count       <= '0;
      pending     <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      pending <= accept;
      if (accept) fetch_addr <= fetch_addr + 1'b1;
      // The returning byte is always written, even when it is consumed
      // straight from data_in; the head pointer then steps past it.
      if (pending) begin
        q[tail_ptr] <= data_in;
        tail_ptr    <= tail_ptr + 1'b1;
      end
      count <= count + CW'(pending) - pop_count;
      if (assemble) begin
        opcode      <= win[0];
        operand     <= {op_hi, op_lo};
        instr_len   <= head_len;
        instr_pc    <= head_addr;
        instr_valid <= 1'b1;
        head_ptr    <= head_ptr + PW'(head_len);
        head_addr   <= head_addr + ADDR_WIDTH'(head_len);
      end else if (instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int EW = 42;  // {opcode 8, operand 16, len 2, pc 16}

  logic        phi1 = 1'b0;
  logic        reset_n;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_grant;
  logic [7:0]  data_in;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;

  logic [7:0]    mem [0:65535];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs;
  int            checks = 0;
  int            errors = 0;
  logic          resp_acc;
  logic [15:0]   resp_addr;

  assign obs = {opcode, operand, instr_len, instr_pc};

  fetch_queue #(
    .ADDR_WIDTH(16), .REG_WIDTH(8), .QUEUE_DEPTH(4), .INSTRUCTION_BASE(16'h0600)
  ) dut (
    .phi1(phi1), .reset_n(reset_n), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_grant(mem_grant), .data_in(data_in), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .opcode(opcode), .operand(operand),
    .instr_len(instr_len), .instr_pc(instr_pc)
  );

  // ---------------- clock ----------------
  always #5 phi1 = ~phi1;

  // ---------------- memory responder: data one cycle after accept ----------------
  always @(posedge phi1) begin
    resp_acc  = (mem_req === 1'b1) && (mem_grant === 1'b1);
    resp_addr = mem_addr;
    #1;
    data_in = resp_acc ? mem[resp_addr] : 8'($urandom);
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_len(input logic [7:0] op);
    logic [1:0] cc;
    logic [2:0] b;
    cc = op[1:0];
    b  = op[4:2];
    if (op == 8'h20) return 2'd3;
    if (op == 8'hA0 || op == 8'hA2 || op == 8'hC0 || op == 8'hE0) return 2'd2;
    if (cc == 2'b01) begin
      if (b == 3'd3 || b == 3'd6 || b == 3'd7) return 2'd3;
      return 2'd2;
    end
    if (cc == 2'b11) return 2'd1;
    if (cc == 2'b10 && b == 3'd4) return 2'd1;
    if (b == 3'd3 || b == 3'd7) return 2'd3;
    if (b == 3'd1 || b == 3'd4 || b == 3'd5) return 2'd2;
    return 2'd1;
  endfunction

  task automatic push_stream(input logic [15:0] start, input int n);
    logic [15:0] pc;
    logic [1:0]  l;
    logic [7:0]  lo, hi;
    pc = start;
    for (int i = 0; i < n; i++) begin
      l  = ref_len(mem[pc]);
      lo = (l >= 2'd2) ? mem[pc + 16'd1] : 8'h00;
      hi = (l == 2'd3) ? mem[pc + 16'd2] : 8'h00;
      exp_q.push_back({mem[pc], hi, lo, l, pc});
      pc = pc + 16'(l);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_redirect(input logic [15:0] a);
    @(negedge phi1);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    @(posedge phi1); #1;
    redirect_valid = 1'b0;
    exp_q.delete();
  endtask

  // Scoreboard consumer; entered just after a posedge.
  task automatic drain(input int n, input bit rnd);
    int got;
    int budget;
    logic [EW-1:0] e;
    got = 0;
    budget = 400;
    instr_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    mem_grant   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    while (got < n && budget > 0) begin
      @(negedge phi1);
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra got=%h exp=none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL sb_instr got=%h exp=%h", obs, e);
          end
        end
        got++;
      end
      @(posedge phi1); #1;
      budget--;
      if (got >= n) instr_ready = 1'b0;
      else begin
        instr_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        mem_grant   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
    instr_ready = 1'b0;
    mem_grant   = 1'b1;
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL sb_timeout got=%0d exp=%0d", got, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    instr_ready = 1'b0;
    repeat (2) @(posedge phi1);
    #1;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL rst_outputs got=%h exp=0", obs); end
    exp_q.delete();
    push_stream(16'h0600, 6);
    reset_n = 1'b1;
    instr_ready = 1'b1;
    @(negedge phi1);  // cycle 0
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0600 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_c0 got=req%b addr%h v%b exp=req1 addr0600 v0", mem_req, mem_addr, instr_valid);
    end
    @(negedge phi1);  // cycle 1
    checks++;
    if (mem_addr !== 16'h0601 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_c1 got=addr%h v%b exp=addr0601 v0", mem_addr, instr_valid);
    end
    for (int i = 0; i < 3; i++) begin  // cycles 2..4, one instruction each
      @(negedge phi1);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'h0600 + 16'(i) || obs !== exp_q[0]) begin
        errors++;
        $display("FAIL rst_stream%0d got=v%b %h exp=v1 %h", i, instr_valid, obs, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    @(posedge phi1); #1;
    drain(3, 1'b0);
  endtask

  task automatic test_mixed_lengths();
    do_redirect(16'h0700);
    push_stream(16'h0700, 4);
    @(negedge phi1);  // k+1
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0700) begin
      errors++;
      $display("FAIL mix_addr got=req%b %h exp=req1 0700", mem_req, mem_addr);
    end
    repeat (3) @(negedge phi1);  // k+4
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL mix_early got=%b exp=0", instr_valid); end
    @(negedge phi1);  // k+5
    checks++;
    if (instr_valid !== 1'b1 || obs !== {8'hAD, 16'h1234, 2'd3, 16'h0700}) begin
      errors++;
      $display("FAIL mix_first got=v%b %h exp=v1 %h", instr_valid, obs, {8'hAD, 16'h1234, 2'd3, 16'h0700});
    end
    @(posedge phi1); #1;
    drain(4, 1'b0);
  endtask

  task automatic test_backpressure();
    do_redirect(16'h0800);
    push_stream(16'h0800, 20);
    repeat (8) @(negedge phi1);
    for (int i = 0; i < 10; i++) begin
      @(negedge phi1);
      checks++;
      if (instr_valid !== 1'b1 || obs !== exp_q[0]) begin
        errors++;
        $display("FAIL bp_hold%0d got=v%b %h exp=v1 %h", i, instr_valid, obs, exp_q[0]);
      end
    end
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req got=%b exp=0", mem_req); end
    @(posedge phi1); #1;
    drain(20, 1'b1);
  endtask

  task automatic test_redirect_inflight();
    do_redirect(16'h0A00);
    @(negedge phi1);  // accept of 0A00 at the end of this cycle
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0A00) begin
      errors++;
      $display("FAIL rd_setup got=req%b %h exp=req1 0A00", mem_req, mem_addr);
    end
    @(negedge phi1);  // read in flight: redirect now
    redirect_valid = 1'b1;
    redirect_addr  = 16'h8000;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL rd_req_low got=%b exp=0", mem_req); end
    @(posedge phi1); #1;
    redirect_valid = 1'b0;
    exp_q.delete();
    push_stream(16'h8000, 6);
    @(negedge phi1);  // k+1
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h8000) begin
      errors++;
      $display("FAIL rd_addr got=req%b %h exp=req1 8000", mem_req, mem_addr);
    end
    @(negedge phi1);  // k+2
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_early got=%b exp=0", instr_valid); end
    @(negedge phi1);  // k+3
    checks++;
    if (instr_valid !== 1'b1 || obs !== {8'hE8, 16'h0000, 2'd1, 16'h8000}) begin
      errors++;
      $display("FAIL rd_first got=v%b %h exp=v1 %h", instr_valid, obs, {8'hE8, 16'h0000, 2'd1, 16'h8000});
    end
    @(posedge phi1); #1;
    drain(6, 1'b0);
  endtask

  task automatic test_grant_wrap();
    do_redirect(16'hFFFE);
    @(negedge phi1);
    checks++;
    if (mem_addr !== 16'hFFFE) begin errors++; $display("FAIL gw_start got=%h exp=FFFE", mem_addr); end
    @(posedge phi1); #1;
    mem_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge phi1);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'hFFFF) begin
        errors++;
        $display("FAIL gw_stall%0d got=req%b %h exp=req1 FFFF", i, mem_req, mem_addr);
      end
    end
    @(posedge phi1); #1;
    mem_grant = 1'b1;
    @(negedge phi1);
    checks++;
    if (mem_addr !== 16'hFFFF) begin errors++; $display("FAIL gw_grant got=%h exp=FFFF", mem_addr); end
    @(negedge phi1);
    checks++;
    if (mem_addr !== 16'h0000) begin errors++; $display("FAIL gw_wrap got=%h exp=0000", mem_addr); end
    push_stream(16'hFFFE, 4);
    repeat (2) @(negedge phi1);
    checks++;
    if (instr_valid !== 1'b1 || obs !== {8'hAD, 16'h1234, 2'd3, 16'hFFFE}) begin
      errors++;
      $display("FAIL gw_instr got=v%b %h exp=v1 %h", instr_valid, obs, {8'hAD, 16'h1234, 2'd3, 16'hFFFE});
    end
    @(posedge phi1); #1;
    drain(4, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_redirect(16'h0B00);
    @(posedge phi1); #1;  // read of 0B00 now in flight
    reset_n = 1'b0;
    @(posedge phi1); #1;
    reset_n = 1'b1;
    checks++;
    if (instr_valid !== 1'b0 || obs !== '0) begin
      errors++;
      $display("FAIL mid_rst_out got=v%b %h exp=v0 0", instr_valid, obs);
    end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0600) begin
      errors++;
      $display("FAIL mid_rst_addr got=req%b %h exp=req1 0600", mem_req, mem_addr);
    end
    exp_q.delete();
    push_stream(16'h0600, 5);
    drain(5, 1'b0);
  endtask

  // ---------------- main ----------------
  initial begin
    logic [15:0] a;
    reset_n        = 1'b0;
    mem_grant      = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = 16'h0000;
    instr_ready    = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'h0700] = 8'hAD; mem[16'h0701] = 8'h34; mem[16'h0702] = 8'h12;
    mem[16'h0703] = 8'hA9; mem[16'h0704] = 8'h05;
    for (int i = 0; i < 256; i++) begin
      a = 16'h0800 + 16'(i);
      mem[a] = 8'($urandom);
    end
    for (int i = 0; i < 16; i++) begin
      a = 16'h0A00 + 16'(i);
      mem[a] = 8'h18;
      a = 16'h0B00 + 16'(i);
      mem[a] = 8'h38;
    end
    mem[16'h8000] = 8'hE8; mem[16'h8001] = 8'hC8;
    mem[16'hFFFE] = 8'hAD; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;

    test_reset();
    test_mixed_lengths();
    test_backpressure();
    test_redirect_inflight();
    test_grant_wrap();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
